// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/HALT control, program counter with branch,
// decoder mode and compare-flag registers, and a saturating RUN-cycle counter.
module fetch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       NextState,
  input  logic [8:0]       PrevInstructionIn,
  input  logic             BranchEn,
  input  logic [8:0]       BranchTarget,
  input  logic             Ack,
  input  logic             CMPLoadEn,
  input  logic [2:0]       ALUFlags,
  output logic [PC_W-1:0]  ProgCtr,
  output logic [1:0]       CurrState,
  output logic [8:0]       PrevInstruction,
  output logic [2:0]       CMPBits,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [1:0]       r_curr_state;
  logic [8:0]       r_prev_instr;
  logic [2:0]       r_cmp_bits;
  logic             r_running;
  logic             r_done;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [PC_W-1:0]  w_branch_pc;
  logic [1:0]       w_mode_next;

  // The cast zero-extends or truncates the 9-bit target to the ROM address width
  assign w_branch_pc = PC_W'(BranchTarget);
  assign w_mode_next = (NextState == 2'b11) ? 2'b00 : NextState;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (Start) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_RUN;
        S_RUN:   w_state_next = Ack ? S_HALT : S_RUN;
        S_HALT:  w_state_next = S_HALT;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc         <= START_PC;
      r_curr_state <= 2'b00;
      r_prev_instr <= 9'd0;
      r_cmp_bits   <= 3'd0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_cycle_cnt  <= '0;
    end else if (Start) begin
      r_pc         <= START_PC;
      r_curr_state <= 2'b00;
      r_prev_instr <= 9'd0;
      r_cmp_bits   <= 3'd0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_cycle_cnt  <= '0;
    end else begin
      case (r_state)
        // Datapath already holds the idle values; only the status flag changes
        S_IDLE: begin
          r_running <= 1'b1;
          r_done    <= 1'b0;
        end
        S_RUN: begin
          if (r_cycle_cnt != CNT_MAX) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          end
          if (CMPLoadEn) begin
            r_cmp_bits <= ALUFlags;
          end
          if (Ack) begin
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_pc         <= BranchEn ? w_branch_pc : r_pc + PC_W'(1);
            r_curr_state <= w_mode_next;
            r_prev_instr <= PrevInstructionIn;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ProgCtr         = r_pc;
  assign CurrState       = r_curr_state;
  assign PrevInstruction = r_prev_instr;
  assign CMPBits         = r_cmp_bits;
  assign Running         = r_running;
  assign Done            = r_done;
  assign CycleCount      = r_cycle_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (wide PC, and a narrow PC with a
// small counter and nonzero start address) driven together and compared to a model.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b1;
  logic [1:0] NextState = 2'd0;
  logic [8:0] PrevInstructionIn = 9'd0;
  logic       BranchEn = 1'b0;
  logic [8:0] BranchTarget = 9'd0;
  logic       Ack = 1'b0;
  logic       CMPLoadEn = 1'b0;
  logic [2:0] ALUFlags = 3'd0;

  logic [9:0]  a_pc;
  logic [1:0]  a_cs;
  logic [8:0]  a_pi;
  logic [2:0]  a_cmp;
  logic        a_run, a_done;
  logic [15:0] a_cc;
  logic [3:0]  b_pc;
  logic [1:0]  b_cs;
  logic [8:0]  b_pi;
  logic [2:0]  b_cmp;
  logic        b_run, b_done;
  logic [3:0]  b_cc;

  always #5 Clk = ~Clk;

  fetch_unit #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .NextState(NextState),
    .PrevInstructionIn(PrevInstructionIn), .BranchEn(BranchEn), .BranchTarget(BranchTarget),
    .Ack(Ack), .CMPLoadEn(CMPLoadEn), .ALUFlags(ALUFlags),
    .ProgCtr(a_pc), .CurrState(a_cs), .PrevInstruction(a_pi), .CMPBits(a_cmp),
    .Running(a_run), .Done(a_done), .CycleCount(a_cc)
  );

  fetch_unit #(.PC_W(4), .START_ADDR(3), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .NextState(NextState),
    .PrevInstructionIn(PrevInstructionIn), .BranchEn(BranchEn), .BranchTarget(BranchTarget),
    .Ack(Ack), .CMPLoadEn(CMPLoadEn), .ALUFlags(ALUFlags),
    .ProgCtr(b_pc), .CurrState(b_cs), .PrevInstruction(b_pi), .CMPBits(b_cmp),
    .Running(b_run), .Done(b_done), .CycleCount(b_cc)
  );

  // Model phases: 0 idle, 1 running, 2 halted
  typedef struct {
    int st;
    int pc;
    int cs;
    int pi;
    int cmp;
    int cc;
  } model_t;

  model_t ma, mb;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  function automatic model_t idle_model(int start_addr);
    model_t m;
    m.st = 0; m.pc = start_addr; m.cs = 0; m.pi = 0; m.cmp = 0; m.cc = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int pc_w, int start_addr, int cnt_w);
    model_t n;
    int pc_mod;
    int cnt_max;
    n = m;
    pc_mod = 1 << pc_w;
    cnt_max = (1 << cnt_w) - 1;
    if (Start) return idle_model(start_addr);
    if (m.st == 0) begin
      n.st = 1;
    end else if (m.st == 1) begin
      if (m.cc < cnt_max) n.cc = m.cc + 1;
      if (CMPLoadEn) n.cmp = int'(ALUFlags);
      if (Ack) begin
        n.st = 2;
      end else begin
        n.pc = BranchEn ? (int'(BranchTarget) % pc_mod) : ((m.pc + 1) % pc_mod);
        n.cs = (NextState == 2'd3) ? 0 : int'(NextState);
        n.pi = int'(PrevInstructionIn);
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("a_pc",   int'(a_pc),   ma.pc);
    check("a_cs",   int'(a_cs),   ma.cs);
    check("a_pi",   int'(a_pi),   ma.pi);
    check("a_cmp",  int'(a_cmp),  ma.cmp);
    check("a_run",  int'(a_run),  int'(ma.st == 1));
    check("a_done", int'(a_done), int'(ma.st == 2));
    check("a_cc",   int'(a_cc),   ma.cc);
    check("b_pc",   int'(b_pc),   mb.pc);
    check("b_cs",   int'(b_cs),   mb.cs);
    check("b_pi",   int'(b_pi),   mb.pi);
    check("b_cmp",  int'(b_cmp),  mb.cmp);
    check("b_run",  int'(b_run),  int'(mb.st == 1));
    check("b_done", int'(b_done), int'(mb.st == 2));
    check("b_cc",   int'(b_cc),   mb.cc);
  endtask

  task automatic step();
    @(posedge Clk);
    ma = model_step(ma, 10, 0, 16);
    mb = model_step(mb, 4, 3, 4);
    #1;
    cyc++;
    check_all();
    $display("[TB] cyc %0d start=%b ack=%b br=%b tgt=%h | a pc=%h cc=%0d run=%b done=%b | b pc=%h cc=%0d",
             cyc, Start, Ack, BranchEn, BranchTarget, a_pc, a_cc, a_run, a_done, b_pc, b_cc);
  endtask

  // Called just after a clock edge: pulses Reset between edges
  task automatic async_reset();
    #2 Reset = 1'b1;
    #1;
    ma = idle_model(0);
    mb = idle_model(3);
    check_all();
    $display("[TB] cyc %0d async reset: a pc=%h run=%b cc=%0d", cyc, a_pc, a_run, a_cc);
    #1 Reset = 1'b0;
  endtask

  task automatic quiet_inputs();
    Start = 1'b0; Ack = 1'b0; BranchEn = 1'b0; CMPLoadEn = 1'b0;
    NextState = 2'd0; BranchTarget = 9'd0; ALUFlags = 3'd0;
  endtask

  initial begin
    ma = idle_model(0);
    mb = idle_model(3);
    #12;
    check_all();
    @(negedge Clk);
    Reset = 1'b0;

    // Start high then low, straight-line fetch
    Start = 1'b1;
    step();
    quiet_inputs();
    PrevInstructionIn = 9'h0A5;
    step();
    check("seq_first_pc", int'(a_pc), 0);
    check("seq_running", int'(a_run), 1);
    repeat (4) step();
    check("seq_pc4", int'(a_pc), 4);
    check("seq_cc4", int'(a_cc), 4);

    // Branch from PC 5 with target mode, then regular mode
    step();
    check("br_pc5", int'(a_pc), 5);
    BranchEn = 1'b1; BranchTarget = 9'h1F0; NextState = 2'b01;
    step();
    check("br_pc_tgt", int'(a_pc), 'h1F0);
    check("br_cs_tgt", int'(a_cs), 1);
    BranchEn = 1'b0; NextState = 2'b00;
    step();
    check("br_cs_reg", int'(a_cs), 0);
    check("br_pc_inc", int'(a_pc), 'h1F1);

    // Compare flags load in RUN
    CMPLoadEn = 1'b1; ALUFlags = 3'b011;
    step();
    check("cmp_load", int'(a_cmp), 3);
    CMPLoadEn = 1'b0; ALUFlags = 3'b100;
    step();
    check("cmp_hold", int'(a_cmp), 3);

    // Ack wins over branch; HALT ignores branch and compare load
    BranchEn = 1'b1; BranchTarget = 9'd7;
    step();
    check("halt_pre_pc", int'(a_pc), 7);
    Ack = 1'b1; BranchTarget = 9'h055;
    step();
    check("halt_pc", int'(a_pc), 7);
    check("halt_done", int'(a_done), 1);
    check("halt_run", int'(a_run), 0);
    Ack = 1'b0; BranchTarget = 9'h1FF; CMPLoadEn = 1'b1; ALUFlags = 3'b100;
    repeat (2) step();
    check("halt_pc_held", int'(a_pc), 7);
    check("halt_cmp_held", int'(a_cmp), 3);
    quiet_inputs();
    Start = 1'b1;
    step();
    check("restart_pc", int'(a_pc), 0);
    check("restart_cc", int'(a_cc), 0);
    check("restart_done", int'(a_done), 0);

    // Reserved mode maps to 00; async reset mid-run at 0x2A
    Start = 1'b0;
    step();
    BranchEn = 1'b1; BranchTarget = 9'h029; NextState = 2'b10;
    step();
    check("mode_imm", int'(a_cs), 2);
    BranchTarget = 9'h02A; NextState = 2'b11;
    step();
    check("mode_rsvd", int'(a_cs), 0);
    check("pre_rst_pc", int'(a_pc), 'h2A);
    async_reset();
    check("rst_pc", int'(a_pc), 0);
    check("rst_run", int'(a_run), 0);

    // Narrow instance: PC wrap from 15 to 0 and counter saturation
    quiet_inputs();
    step();
    repeat (13) step();
    check("wrap_pc", int'(b_pc), 0);
    check("wrap_cc", int'(b_cc), 13);
    repeat (4) step();
    check("sat_cc", int'(b_cc), 15);
    check("sat_pc", int'(b_pc), 4);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      Start             = ($urandom_range(0, 39) == 0);
      Ack               = ($urandom_range(0, 24) == 0);
      BranchEn          = ($urandom_range(0, 3) == 0);
      CMPLoadEn         = ($urandom_range(0, 2) == 0);
      NextState         = 2'($urandom_range(0, 3));
      PrevInstructionIn = 9'($urandom_range(0, 511));
      BranchTarget      = 9'($urandom_range(0, 511));
      ALUFlags          = 3'($urandom_range(0, 7));
      step();
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, 10, program-counter width; instruction ROM depth is 2**PC_W.
REQ-002 Parameter: START_ADDR, 0, program counter value loaded on reset and on restart.
REQ-003 Parameter: CNT_W, 16, width of the saturating cycle counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port: Clk  input  1  rising-edge clock.
REQ-006 Port: Reset  input  1  asynchronous active-high reset.
REQ-007 Port: Start  input  1  level request; high = hold idle/restart; low while idle = begin run.
REQ-008 Port: NextState  input  2  decoder mode for next instruction (00 regular, 01 target, 10 immediate, 11 reserved).
REQ-009 Port: PrevInstructionIn  input  9  decoder's copy of the current instruction.
REQ-010 Port: BranchEn  input  1  decoder branch-taken strobe.
REQ-011 Port: BranchTarget  input  9  absolute branch destination.
REQ-012 Port: Ack  input  1  decoder end-of-program strobe.
REQ-013 Port: CMPLoadEn  input  1  capture ALU flags into compare register.
REQ-014 Port: ALUFlags  input  3  {zero, equal, greater-than} from ALU.
REQ-015 Port: ProgCtr  output  PC_W  instruction ROM address.
REQ-016 Port: CurrState  output  2  registered decoder mode.
REQ-017 Port: PrevInstruction  output  9  registered previous instruction.
REQ-018 Port: CMPBits  output  3  registered compare flags.
REQ-019 Port: Running  output  1  high in RUN.
REQ-020 Port: Done  output  1  high in HALT.
REQ-021 Port: CycleCount  output  CNT_W  RUN cycles executed in current program.

Function
REQ-022 FSM states: IDLE, RUN, HALT; all outputs registered; every update visible the cycle after the causing edge.
REQ-023 Start high in any state SHALL force IDLE next cycle, overriding all other inputs.
REQ-024 IDLE: ProgCtr=START_ADDR, CurrState=00, PrevInstruction=0, CMPBits=0, CycleCount=0, Running=0, Done=0.
REQ-025 IDLE with Start low SHALL go to RUN next cycle; ProgCtr stays START_ADDR so the first fetch is START_ADDR.
REQ-026 RUN, Ack high: go to HALT; ProgCtr, CurrState, PrevInstruction, CMPBits held; CycleCount still increments for this cycle.
REQ-027 RUN, Ack low, BranchEn high: ProgCtr = BranchTarget zero-extended to PC_W (truncated if PC_W<9).
REQ-028 RUN, Ack low, BranchEn low: ProgCtr = ProgCtr+1 modulo 2**PC_W (all-ones wraps to 0).
REQ-029 Ack and BranchEn both high SHALL take Ack; no branch.
REQ-030 RUN, Ack low: CurrState <= NextState, except 11 SHALL load 00; PrevInstruction <= PrevInstructionIn.
REQ-031 RUN, CMPLoadEn high: CMPBits <= ALUFlags (also on an Ack cycle); otherwise held.
REQ-032 CycleCount increments by 1 on every RUN cycle, saturates at all-ones, never wraps.
REQ-033 HALT: all registers held, Done=1, Running=0; exits only via Start high (REQ-023).
REQ-034 BranchEn, Ack, CMPLoadEn SHALL be ignored outside RUN.

Reset
REQ-035 Reset high SHALL asynchronously force IDLE and REQ-024 values, including mid-RUN or mid-branch, with no glitch to other values.
REQ-036 After Reset falls, the block SHALL follow REQ-023/REQ-025 from the next rising edge.

Verification
REQ-037 Reset, Start 1 then 0, no branches for 4 cycles -> ProgCtr 0,0,1,2,3; Running=1; CycleCount=4.
REQ-038 RUN at ProgCtr=5, BranchEn=1, BranchTarget=0x1F0 -> next ProgCtr=0x1F0; with NextState=01 CurrState=01, then 00 after following cycle NextState=00.
REQ-039 PC_W=4, ProgCtr=15, no branch -> ProgCtr=0; CycleCount continues incrementing.
REQ-040 Ack=1 and BranchEn=1 same cycle at ProgCtr=7 -> HALT, ProgCtr stays 7, Done=1, further BranchEn ignored; Start=1 -> IDLE, ProgCtr=0, CycleCount=0.
REQ-041 CMPLoadEn=1 with ALUFlags=3'b011 in RUN -> CMPBits=011; same in HALT -> CMPBits unchanged.
REQ-042 Reset asserted mid-RUN between edges at ProgCtr=0x2A -> ProgCtr=0, state IDLE immediately; NextState=11 in RUN -> CurrState=00.
